small_fifo_rr_sched: RTL and testbench

//  Packet-granular round-robin scheduler draining N small_fifo input queues into one output port.

---
 rtl/small_fifo_rr_sched.sv | 103 ++++++++++
 tb/tb_small_fifo_rr_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/small_fifo_rr_sched.sv
// rtl/small_fifo_rr_sched.sv - packet-granular round-robin scheduler draining N small_fifo queues to one port
module small_fifo_rr_sched #(
  parameter int NUM_QUEUES = 4,
  parameter int WIDTH      = 72,
  parameter int EOP_BIT    = 71,
  parameter int QID_W      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_QUEUES-1:0]       q_empty,
  output logic [NUM_QUEUES-1:0]       q_rd_en,
  input  logic [NUM_QUEUES*WIDTH-1:0] q_dout,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_wr,
  input  logic                        out_rdy,
  output logic [QID_W-1:0]            grant_id,
  output logic                        busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state, state_nx;
  logic [QID_W-1:0] last_grant;
  logic [QID_W-1:0] winner;
  logic             any_req;
  logic             rd_pend;
  logic             rd_now;
  logic             eop_now;
  logic             cur_empty;
  logic [WIDTH-1:0] cur_word;

  // Decoded compare rather than a direct index keeps non-power-of-two queue counts in range.
  always_comb begin
    cur_word  = '0;
    cur_empty = 1'b1;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (grant_id == QID_W'(i)) begin
        cur_word  = q_dout[i*WIDTH +: WIDTH];
        cur_empty = q_empty[i];
      end
    end
  end

  // Search upward from the queue after the last grant, wrapping around.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      idx = (int'(last_grant) + k) % NUM_QUEUES;
      if (!any_req && !q_empty[idx]) begin
        any_req = 1'b1;
        winner  = QID_W'(idx);
      end
    end
  end

  assign eop_now = rd_pend && cur_word[EOP_BIT];
  assign rd_now  = (state == XFER) && !cur_empty && out_rdy && !eop_now;

  always_comb begin
    q_rd_en = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      q_rd_en[i] = rd_now && (grant_id == QID_W'(i));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = XFER;
      XFER:    if (eop_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_pend    <= 1'b0;
      grant_id   <= '0;
      last_grant <= QID_W'(NUM_QUEUES - 1);
    end else begin
      state   <= state_nx;
      rd_pend <= rd_now;
      if (state == IDLE && any_req) begin
        grant_id   <= winner;
        last_grant <= winner;
      end
    end
  end

  assign out_wr   = rd_pend;
  assign out_data = cur_word;
  assign busy     = (state == XFER);

  a_rd_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(q_rd_en));
  a_rd_not_empty: assert property (@(posedge clk) disable iff (!reset_n) (q_rd_en & q_empty) == '0);
  // The release cycle still has busy high, so this covers the same-cycle-release case too.
  a_wr_busy: assert property (@(posedge clk) disable iff (!reset_n) out_wr |-> busy);

endmodule

// File: tb/tb_small_fifo_rr_sched.sv
// tb/tb_small_fifo_rr_sched.sv - directed scoreboard bench for small_fifo_rr_sched
module tb_small_fifo_rr_sched;
  localparam int N = 4;
  localparam int W = 72;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     q_empty;
  logic [N-1:0]     q_rd_en;
  logic [N*W-1:0]   q_dout;
  logic [W-1:0]     out_data;
  logic             out_wr;
  logic             out_rdy;
  logic [1:0]       grant_id;
  logic             busy;

  logic [W-1:0] mq [N][$];
  logic [W-1:0] sb [$];
  int           out_cycs [$];
  int           cyc;
  int           errors;
  int           checks;

  small_fifo_rr_sched #(.NUM_QUEUES(N), .WIDTH(W), .EOP_BIT(71), .QID_W(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .q_empty  (q_empty),
    .q_rd_en  (q_rd_en),
    .q_dout   (q_dout),
    .out_data (out_data),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int q, input int p, input int w, input bit eop);
    return {eop, 39'd0, 8'(q), 8'(p), 16'(w)};
  endfunction

  task automatic put(input int q, input logic [W-1:0] d);
    mq[q].push_back(d);
    q_empty[q] = 1'b0;
  endtask

  task automatic pkt(input int q, input int p, input int n, input bit to_sb);
    logic [W-1:0] d;
    for (int w = 0; w < n; w++) begin
      d = mk(q, p, w, w == n - 1);
      put(q, d);
      if (to_sb) sb.push_back(d);
    end
  endtask

  // One clock cycle: sample DUT at mid-cycle, then model the queues' 1-cycle read latency.
  task automatic tick();
    logic [W-1:0] nd [N];
    logic [N-1:0] rd;
    #2;
    rd = q_rd_en;
    chk("rd_onehot0", W'($onehot0(rd)), W'(1));
    chk("rd_to_empty", W'(rd & q_empty), '0);
    for (int i = 0; i < N; i++) begin
      nd[i] = q_dout[i*W +: W];
      if (rd[i] && mq[i].size() > 0) nd[i] = mq[i].pop_front();
    end
    if (out_wr) begin
      out_cycs.push_back(cyc);
      if (sb.size() == 0) chk("sb_underflow", W'(sb.size()), W'(1));
      else chk("out_data", out_data, sb.pop_front());
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      q_dout[i*W +: W] = nd[i];
      q_empty[i] = (mq[i].size() == 0);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, W'(sb.size()), '0);
  endtask

  task automatic chk_gaps(input string tag, input int exp[$]);
    chk({tag, "_nwords"}, W'(out_cycs.size()), W'(exp.size() + 1));
    for (int k = 0; k < exp.size() && k + 1 < out_cycs.size(); k++)
      chk({tag, "_gap"}, W'(out_cycs[k+1] - out_cycs[k]), W'(exp[k]));
  endtask

  task automatic flush_queues();
    for (int i = 0; i < N; i++) mq[i].delete();
    q_empty = '1;
    q_dout  = '0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    reset_n = 1'b0;
    out_rdy = 1'b1;
    q_empty = '1;
    q_dout  = '0;

    // Reset with all queues backlogged; then strict round-robin q0,q1,q2,q3,q0.
    pkt(0, 0, 2, 1'b1);
    pkt(1, 0, 2, 1'b1);
    pkt(2, 0, 2, 1'b1);
    pkt(3, 0, 2, 1'b1);
    pkt(0, 1, 2, 1'b1);
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rst_rd_en", W'(q_rd_en), '0);
      chk("rst_out_wr", W'(out_wr), '0);
      chk("rst_busy", W'(busy), '0);
    end
    reset_n = 1'b1;
    tick();
    chk("t1_first_grant", W'(grant_id), W'(0));
    chk("t1_busy", W'(busy), W'(1));
    out_cycs.delete();
    drain("t3", 100);
    chk("t3_busy_end", W'(busy), '0);
    chk_gaps("t3", '{1, 3, 1, 3, 1, 3, 1, 3, 1});

    // Single queue, 3-word packet.
    pkt(1, 1, 3, 1'b1);
    tick();
    chk("t2_grant", W'(grant_id), W'(1));
    chk("t2_busy", W'(busy), W'(1));
    out_cycs.delete();
    drain("t2", 30);
    chk("t2_busy_fall", W'(busy), '0);
    chk_gaps("t2", '{1, 1});

    // Backpressure: out_rdy low for 2 cycles right after word 2 is read.
    pkt(3, 2, 4, 1'b1);
    tick();
    chk("t4_grant", W'(grant_id), W'(3));
    out_cycs.delete();
    tick();
    tick();
    out_rdy = 1'b0;
    tick();
    tick();
    out_rdy = 1'b1;
    drain("t4", 30);
    chk("t4_busy_end", W'(busy), '0);
    chk_gaps("t4", '{1, 3, 1});

    // Underrun on q2 mid-packet while q0 waits.
    put(2, mk(2, 3, 0, 1'b0));
    sb.push_back(mk(2, 3, 0, 1'b0));
    sb.push_back(mk(2, 3, 1, 1'b0));
    sb.push_back(mk(2, 3, 2, 1'b1));
    tick();
    chk("t5_grant", W'(grant_id), W'(2));
    pkt(0, 3, 2, 1'b1);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("t5_grant_held", W'(grant_id), W'(2));
    chk("t5_busy_held", W'(busy), W'(1));
    chk("t5_no_rd", W'(q_rd_en), '0);
    put(2, mk(2, 3, 1, 1'b0));
    put(2, mk(2, 3, 2, 1'b1));
    drain("t5", 60);
    chk("t5_busy_end", W'(busy), '0);

    // Reset during word 2 of 4; arbitration then restarts from queue 0.
    pkt(1, 4, 4, 1'b1);
    tick();
    chk("t6_grant", W'(grant_id), W'(1));
    tick();
    tick();
    chk("t6_word2_present", W'(out_wr), W'(1));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out_wr", W'(out_wr), '0);
    chk("t6_rst_busy", W'(busy), '0);
    chk("t6_rst_rd_en", W'(q_rd_en), '0);
    chk("t6_rst_grant", W'(grant_id), '0);
    sb.delete();
    flush_queues();
    tick();
    tick();
    chk("t6_hold_busy", W'(busy), '0);
    reset_n = 1'b1;
    pkt(0, 5, 2, 1'b1);
    pkt(3, 5, 2, 1'b1);
    tick();
    chk("t6_restart_grant", W'(grant_id), W'(0));
    drain("t6", 40);
    chk("t6_busy_end", W'(busy), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
